// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types and defaults for the interrupt controller
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RESTORE = 2'd3
  } state_t;

  localparam int MISS_W_DEF = 4;

endpackage

// File: rtl/int_controller_edge_detect.sv
// rtl/int_controller_edge_detect.sv - rising-edge detector on a clk-synchronous input
// The history register resets to 1 so a level held high across reset gives no edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev <= 1'b1;
    else     r_prev <= in;
  end

  assign rise = in & ~r_prev;

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - single-source interrupt controller with C/Z shadowing
// Latches button edges, requests service, saves flags on ack and restores on RETIE.
module int_controller
  import int_pkg::*;
#(
  parameter int MISS_W = MISS_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              int_in,
  input  logic              sei,
  input  logic              cli,
  input  logic              ack,
  input  logic              retie,
  input  logic              flg_c,
  input  logic              flg_z,
  output logic              int_req,
  output logic              i_flag,
  output logic              shadow_c,
  output logic              shadow_z,
  output logic              restore,
  output logic [MISS_W-1:0] miss_cnt
);

  state_t            r_state;
  state_t            w_next;
  logic              r_pending;
  logic              r_i_flag;
  logic              r_shadow_c;
  logic              r_shadow_z;
  logic [MISS_W-1:0] r_miss_cnt;
  logic              w_edge;
  logic              w_take_ack;
  logic              w_en_ctl;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (int_in),
    .rise (w_edge)
  );

  assign w_take_ack = (r_state == ST_REQ) && ack;
  assign w_en_ctl   = (r_state == ST_IDLE) || (r_state == ST_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (r_pending && r_i_flag) w_next = ST_REQ;
      ST_REQ: begin
        if (ack)      w_next = ST_SERVICE;
        else if (cli) w_next = ST_IDLE;
      end
      ST_SERVICE: if (retie) w_next = ST_RESTORE;
      ST_RESTORE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // An edge coinciding with ack keeps pending set and is not counted as a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_miss_cnt <= '0;
    end else begin
      if (w_edge)          r_pending <= 1'b1;
      else if (w_take_ack) r_pending <= 1'b0;
      if (w_edge && r_pending && !w_take_ack && !(&r_miss_cnt))
        r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_flag   <= 1'b0;
      r_shadow_c <= 1'b0;
      r_shadow_z <= 1'b0;
    end else begin
      if (w_take_ack) begin
        r_i_flag   <= 1'b0;
        r_shadow_c <= flg_c;
        r_shadow_z <= flg_z;
      end else if (r_state == ST_RESTORE) begin
        r_i_flag <= 1'b1;
      end else if (w_en_ctl) begin
        if (cli)      r_i_flag <= 1'b0;
        else if (sei) r_i_flag <= 1'b1;
      end
    end
  end

  assign int_req  = (r_state == ST_REQ);
  assign restore  = (r_state == ST_RESTORE);
  assign i_flag   = r_i_flag;
  assign shadow_c = r_shadow_c;
  assign shadow_z = r_shadow_z;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed self-checking bench for int_controller
module tb_int_controller;

  logic       clk = 1'b0;
  logic       rst, int_in, sei, cli, ack, retie, flg_c, flg_z;
  logic       int_req, i_flag, shadow_c, shadow_z, restore;
  logic [3:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int_controller #(.MISS_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .int_in   (int_in),
    .sei      (sei),
    .cli      (cli),
    .ack      (ack),
    .retie    (retie),
    .flg_c    (flg_c),
    .flg_z    (flg_z),
    .int_req  (int_req),
    .i_flag   (i_flag),
    .shadow_c (shadow_c),
    .shadow_z (shadow_z),
    .restore  (restore),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; int_in = 1'b0; sei = 1'b0; cli = 1'b0; ack = 1'b0;
    retie = 1'b0; flg_c = 1'b0; flg_z = 1'b0;
    tick(); tick();
    check("rst_int_req", int_req, 0);
    check("rst_i_flag", i_flag, 0);
    check("rst_restore", restore, 0);
    check("rst_miss", miss_cnt, 0);
    check("rst_shadow_c", shadow_c, 0);
    rst = 1'b0;
    tick();

    // sei, then a held edge -> one request two cycles later
    sei = 1'b1; tick(); sei = 1'b0;
    check("sei_sets_iflag", i_flag, 1);
    int_in = 1'b1;
    tick();
    check("lat_n1_no_req", int_req, 0);
    tick();
    check("lat_n2_req", int_req, 1);
    flg_c = 1'b1; flg_z = 1'b0; ack = 1'b1;
    tick(); ack = 1'b0;
    check("ack_shadow_c", shadow_c, 1);
    check("ack_shadow_z", shadow_z, 0);
    check("ack_iflag_clr", i_flag, 0);
    check("ack_req_drop", int_req, 0);
    sei = 1'b1; tick(); sei = 1'b0;
    check("svc_sei_ignored", i_flag, 0);
    for (int i = 0; i < 6; i++) tick();
    check("held_no_miss", miss_cnt, 0);
    check("svc_no_restore", restore, 0);
    retie = 1'b1; tick(); retie = 1'b0;
    check("restore_pulse", restore, 1);
    tick();
    check("restore_one_cycle", restore, 0);
    check("restore_iflag", i_flag, 1);
    tick(); tick();
    check("single_request", int_req, 0);
    int_in = 1'b0;
    flg_c = 1'b0; flg_z = 1'b1; ack = 1'b1; retie = 1'b1;
    tick(); ack = 1'b0; retie = 1'b0;
    check("stray_ack_shadow_c", shadow_c, 1);
    check("stray_ack_shadow_z", shadow_z, 0);
    check("stray_retie_restore", restore, 0);
    check("stray_ack_iflag", i_flag, 1);

    // masked edge stays pending until sei
    cli = 1'b1; tick(); cli = 1'b0;
    check("cli_clears", i_flag, 0);
    int_in = 1'b1;
    tick(); tick();
    check("masked_no_req_a", int_req, 0);
    tick();
    check("masked_no_req_b", int_req, 0);
    sei = 1'b1; tick(); sei = 1'b0;
    check("late_sei_iflag", i_flag, 1);
    check("late_sei_n1", int_req, 0);
    tick();
    check("late_sei_n2_req", int_req, 1);
    sei = 1'b1; cli = 1'b1; tick(); sei = 1'b0; cli = 1'b0;
    check("cli_wins_iflag", i_flag, 0);
    check("cli_drops_req", int_req, 0);
    tick();
    check("cli_stays_idle", int_req, 0);

    // 20 coalesced edges saturate the miss counter
    int_in = 1'b0; tick();
    for (int i = 0; i < 20; i++) begin
      int_in = 1'b1; tick();
      int_in = 1'b0; tick();
      if (i == 0)  check("miss_first", miss_cnt, 1);
      if (i == 14) check("miss_reach_15", miss_cnt, 15);
    end
    check("miss_saturated", miss_cnt, 15);
    check("miss_no_req", int_req, 0);

    // edge coinciding with ack -> re-request after restore
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_clears_miss", miss_cnt, 0);
    tick();
    sei = 1'b1; tick(); sei = 1'b0;
    int_in = 1'b1; tick();
    int_in = 1'b0; tick();
    check("s5_req", int_req, 1);
    flg_c = 1'b0; flg_z = 1'b1; ack = 1'b1; int_in = 1'b1;
    tick(); ack = 1'b0;
    check("s5_shadow_z", shadow_z, 1);
    check("s5_shadow_c", shadow_c, 0);
    check("s5_miss_unch", miss_cnt, 0);
    check("s5_req_drop", int_req, 0);
    retie = 1'b1; tick(); retie = 1'b0;
    check("s5_restore", restore, 1);
    tick();
    check("s5_restore_off", restore, 0);
    check("s5_idle_no_req", int_req, 0);
    tick();
    check("s5_rerequest", int_req, 1);
    check("s5_miss_final", miss_cnt, 0);

    // reset during SERVICE abandons the interrupt
    flg_c = 1'b1; flg_z = 1'b1; ack = 1'b1;
    tick(); ack = 1'b0;
    check("s6_in_service_c", shadow_c, 1);
    #3 rst = 1'b1;
    #1;
    check("s6_async_req", int_req, 0);
    check("s6_async_iflag", i_flag, 0);
    check("s6_async_shc", shadow_c, 0);
    check("s6_async_shz", shadow_z, 0);
    check("s6_async_restore", restore, 0);
    retie = 1'b1;
    tick(); tick();
    rst = 1'b0; retie = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s6_no_restore", restore, 0);
      check("s6_no_req", int_req, 0);
    end
    sei = 1'b1; tick(); sei = 1'b0;
    tick(); tick();
    check("s6_held_no_edge", int_req, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
